// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared fetch-path constants and the {pc, instr} FIFO entry type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Purpose  : Bundles the imem, redirect and decode-handshake signals of the IFU.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
    import riscv_pkg::*;

    logic            fetch_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            fetch_fault;

    // master = the fetch unit itself
    modport master (
        input  fetch_en,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output imem_addr,
        output out_valid,
        output out_pc,
        output out_instr,
        output fetch_fault
    );

    modport slave (
        output fetch_en,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  imem_addr,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  fetch_fault
    );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Circular prefetch buffer with push/pop/flush; owns the pointers.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       flush,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic      [$clog2(DEPTH+1)-1:0] count,
    output logic      [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is cleared only on reset so the head reads zero out of reset;
    // a flush just rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC owner, imem address driver, prefetch FIFO and redirect logic.
//            Optional misaligned-redirect trap: define IFU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input wire logic                   clk,
    input wire logic                   rst,
    instruction_fetch_unit_if.master   bus
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam int            EW      = $bits(fetch_entry_t);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head_bits;
    fetch_entry_t    w_head;
    fetch_entry_t    w_wr_entry;
    logic            w_pop;
    logic            w_push;
    logic            w_fault;
    logic [XLEN-1:0] w_redirect_target;

    assign w_pop  = bus.out_valid & bus.out_ready;
    assign w_push = bus.fetch_en & ~bus.redirect_valid & ~w_fault
                  & ((w_count < c_depth) | w_pop);

`ifdef IFU_MISALIGN_TRAP_EN
    logic r_fault;

    // Sticky until the next redirect, which either re-arms or clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fault <= ~is_word_aligned(bus.redirect_pc);
        end
    end

    assign w_fault           = r_fault;
    assign w_redirect_target = bus.redirect_pc;
`else
    assign w_fault           = 1'b0;
    assign w_redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_push) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign w_wr_entry = '{pc: r_pc, instr: bus.imem_instr};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.redirect_valid),
        .wdata (w_wr_entry),
        .count (w_count),
        .head  (w_head_bits)
    );

    assign w_head          = fetch_entry_t'(w_head_bits);
    assign bus.imem_addr   = r_pc;
    assign bus.out_valid   = (w_count != '0);
    assign bus.out_pc      = w_head.pc;
    assign bus.out_instr   = w_head.instr;
    assign bus.fetch_fault = w_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed bench with a queue-based fetch model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] TAG   = 32'h1357_9BDF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    // imem returns an address-tagged word in the same cycle
    assign bus.imem_instr = bus.imem_addr ^ TAG;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending fetches plus the next PC to fetch.
    fetch_entry_t mq[$];
    logic [31:0]  mpc;
    bit           mfault;
    bit           mlive = 0;
    bit           m_pop;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mpc    = 32'h0;
            mfault = 0;
            mlive  = 1;
        end else begin
            m_pop = (mq.size() != 0) && bus.out_ready;
            if (bus.redirect_valid) begin
                mq.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                mfault = (bus.redirect_pc % 4) != 0;
                mpc    = bus.redirect_pc;
`else
                mpc    = bus.redirect_pc - (bus.redirect_pc % 4);
`endif
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (bus.fetch_en && !mfault && mq.size() < DEPTH) begin
                    mq.push_back('{pc: mpc, instr: mpc ^ TAG});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mlive) begin
            chk("imem_addr", bus.imem_addr, mpc);
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("out_pc", bus.out_pc, mq[0].pc);
                chk("out_instr", bus.out_instr, mq[0].instr);
            end
            chk("fetch_fault", 32'(bus.fetch_fault), 32'(mfault));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.fetch_en       = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset values and first-fetch latency
        tick(2);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_pc", bus.out_pc, 32'h0);
        chk("rst out_instr", bus.out_instr, 32'h0);
        chk("rst imem_addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        tick();
        chk("first valid", 32'(bus.out_valid), 32'd1);
        chk("first pc", bus.out_pc, 32'h0);
        chk("first instr", bus.out_instr, 32'h1357_9BDF);
        tick();
        chk("second pc", bus.out_pc, 32'h4);
        tick(4);
        chk("sixth pc", bus.out_pc, 32'h14);

        // Backpressure fills the FIFO, then full-with-pop streaming
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        tick(10);
        chk("stall pc", bus.imem_addr, 32'h10);
        chk("stall head", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("resume head", bus.out_pc, 32'h4);
        chk("resume pc", bus.imem_addr, 32'h14);
        tick(6);

        // Halt drains the FIFO while the PC holds
        bus.fetch_en = 1'b0;
        tick(6);
        chk("halt drained", 32'(bus.out_valid), 32'd0);
        bus.fetch_en = 1'b1;
        tick(2);

        // Redirect with three entries buffered
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        tick(3);
        redirect(32'h0000_00BC);
        chk("redir flush", 32'(bus.out_valid), 32'd0);
        chk("redir addr", bus.imem_addr, 32'hBC);
        tick();
        chk("redir head", bus.out_pc, 32'hBC);
        bus.out_ready = 1'b1;
        tick(3);

        // Back-to-back redirects: last wins
        redirect(32'h0000_0200);
        redirect(32'h0000_0300);
        chk("b2b addr", bus.imem_addr, 32'h300);
        tick();
        chk("b2b head", bus.out_pc, 32'h300);

        // Redirect while halted still moves the PC and flushes
        bus.fetch_en = 1'b0;
        redirect(32'h0000_0400);
        tick(2);
        chk("halt redir addr", bus.imem_addr, 32'h400);
        chk("halt redir valid", 32'(bus.out_valid), 32'd0);
        bus.fetch_en = 1'b1;
        tick(2);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8);
        tick();
        chk("wrap 0", bus.out_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap 1", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap 2", bus.out_pc, 32'h0000_0000);
        tick(2);

        // Misaligned redirect
        redirect(32'h0000_0102);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("mis fault", 32'(bus.fetch_fault), 32'd1);
        chk("mis addr", bus.imem_addr, 32'h102);
        tick(3);
        chk("mis no push", 32'(bus.out_valid), 32'd0);
        redirect(32'h0000_0100);
        chk("mis cleared", 32'(bus.fetch_fault), 32'd0);
        tick();
        chk("mis resume", bus.out_pc, 32'h100);
`else
        chk("mis addr", bus.imem_addr, 32'h100);
        tick();
        chk("mis head", bus.out_pc, 32'h100);
        chk("mis fault", 32'(bus.fetch_fault), 32'd0);
`endif
        tick(3);

        // Reset mid-stream
        rst = 1'b1;
        tick();
        chk("midrst valid", 32'(bus.out_valid), 32'd0);
        chk("midrst addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
